// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   word_t    : 32-bit data word used for operands and results.
//   mult_t    : execute-stage operation selector (CLR, MULT, MULTU, DIV, DIVU).
//   magnitude : absolute value of a word when it is to be treated as signed.
package mult_div_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    CLR   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4
  } mult_t;

  // Index of the final restoring-division step.
  localparam logic [4:0] DIV_LAST_STEP = 5'd31;

  function automatic word_t magnitude(input word_t v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// mdu_div_core: 32-step unsigned restoring divider datapath.
// Ports:
//   clk, resetn         : clock and synchronous active-low reset.
//   load                : capture dividend/divisor magnitudes and clear the remainder.
//   step                : perform one restoring-division step.
//   dividend, divisor   : unsigned operand magnitudes sampled on load.
//   quotient, remainder : running quotient/remainder; final after 32 steps.
module mdu_div_core
  import mult_div_unit_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  load,
  input  logic  step,
  input  word_t dividend,
  input  word_t divisor,
  output word_t quotient,
  output word_t remainder
);

  word_t       rem_q, rem_d;
  word_t       quo_q, quo_d;
  word_t       dvs_q, dvs_d;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  // The quotient register starts holding the dividend; each step shifts its
  // top bit into the partial remainder and a quotient bit into its bottom.
  // A set bit 32 of diff means the trial subtraction went negative.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit.
// Ports:
//   clk, resetn : clock and synchronous active-low reset.
//   op          : operation requested by the execute stage.
//   a, b        : rs / rt operands.
//   flush       : abort any operation; returns to IDLE.
//   adv         : execute stage advances, consuming a completed result.
//   busy        : combinational stall request.
//   done        : result valid on hi/lo.
//   hi, lo      : HI/LO result registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  mult_t op,
  input  word_t a,
  input  word_t b,
  input  logic  flush,
  input  logic  adv,
  output logic  busy,
  output logic  done,
  output word_t hi,
  output word_t lo
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} state_t;

  state_t      state_q, state_d;
  word_t       a_q, a_d;
  word_t       b_q, b_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
  logic        mul_signed_q, mul_signed_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        is_mul, is_div, div_signed;
  logic        div_load, div_step;
  word_t       div_dividend, div_divisor;
  word_t       div_quo, div_rem;
  logic [63:0] product;

  assign is_mul       = (op == MULT) || (op == MULTU);
  assign is_div       = (op == DIV)  || (op == DIVU);
  assign div_signed   = (op == DIV);
  assign div_dividend = magnitude(a, div_signed);
  assign div_divisor  = magnitude(b, div_signed);

  // Sign-extending both operands to 64 bits makes the truncated 64x64 product
  // the correct signed result; zero extension gives the unsigned one.
  assign product = {{32{mul_signed_q & a_q[31]}}, a_q} *
                   {{32{mul_signed_q & b_q[31]}}, b_q};

  mdu_div_core u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_signed_d = mul_signed_q;
    quo_neg_d    = quo_neg_q;
    rem_neg_d    = rem_neg_q;
    cnt_d        = cnt_q;
    busy         = 1'b0;
    div_load     = 1'b0;
    div_step     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          busy         = 1'b1;
          a_d          = a;
          b_d          = b;
          mul_signed_d = (op == MULT);
          state_d      = S_MUL;
        end else if (is_div) begin
          busy = 1'b1;
          // Divide by zero bypasses the iteration with a fixed result.
          if (b == '0) begin
            hi_d    = a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            div_load  = 1'b1;
            quo_neg_d = div_signed && (a[31] ^ b[31]);
            rem_neg_d = div_signed && a[31];
            cnt_d     = '0;
            state_d   = S_DIV;
          end
        end
      end
      S_MUL: begin
        busy    = 1'b1;
        hi_d    = product[63:32];
        lo_d    = product[31:0];
        state_d = S_DONE;
      end
      S_DIV: begin
        busy     = 1'b1;
        div_step = 1'b1;
        if (cnt_q == DIV_LAST_STEP) begin
          state_d = S_SIGN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_SIGN: begin
        busy    = 1'b1;
        lo_d    = quo_neg_q ? (~div_quo + 32'd1) : div_quo;
        hi_d    = rem_neg_q ? (~div_rem + 32'd1) : div_rem;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Returning to IDLE on adv deliberately ignores the op still present.
        if (adv) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything: abandon work, keep the last result.
    if (flush) begin
      state_d  = S_IDLE;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy     = 1'b0;
      div_load = 1'b0;
      div_step = 1'b0;
    end

    if (!resetn) begin
      busy = 1'b0;
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_signed_q <= 1'b0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_signed_q <= mul_signed_d;
      quo_neg_q    <= quo_neg_d;
      rem_neg_q    <= rem_neg_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
